// File: rtl/if_fetch_stage.sv
// if_fetch_stage: RV32I IF stage -- program counter, IMEM address and IF/ID register.
// Optional macro IF_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 40,
    parameter logic [31:0] NOP_INSN   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_ins,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_ins,
    output logic        if_id_valid,
    output logic        fetch_halted,
`ifdef IF_PERF_CNT_EN
    output logic        misalign_err,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`else
    output logic        misalign_err
`endif
);

    typedef enum logic [1:0] {
        ACT_REDIRECT,
        ACT_STALL,
        ACT_FETCH,
        ACT_HALT
    } act_t;

    logic [31:0] pc;
    logic [32:0] pc_end;
    logic        in_range;
    act_t        act;

    // Range check is done one bit wider so a PC near 2^32 never wraps back in range.
    assign pc_end       = {1'b0, pc} + 33'd4;
    assign in_range     = (pc_end <= 33'(IMEM_BYTES));
    assign fetch_halted = !in_range;
    assign imem_pc      = pc;

    always_comb begin
        act = ACT_HALT;
        if (redirect_valid)
            act = ACT_REDIRECT;
        else if (stall)
            act = ACT_STALL;
        else if (in_range)
            act = ACT_FETCH;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= RESET_PC;
            if_id_pc     <= '0;
            if_id_ins    <= NOP_INSN;
            if_id_valid  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            case (act)
                ACT_REDIRECT: begin
                    pc           <= {redirect_pc[31:2], 2'b00};
                    if_id_pc     <= '0;
                    if_id_ins    <= NOP_INSN;
                    if_id_valid  <= 1'b0;
                    misalign_err <= |redirect_pc[1:0];
                end
                ACT_STALL: ;
                ACT_FETCH: begin
                    pc          <= pc + 32'd4;
                    if_id_pc    <= pc;
                    if_id_ins   <= imem_ins;
                    if_id_valid <= 1'b1;
                end
                ACT_HALT: begin
                    if_id_pc    <= pc;
                    if_id_ins   <= NOP_INSN;
                    if_id_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (act == ACT_FETCH)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (act == ACT_STALL)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
